// File: rtl/alu_regfile_pipe_if.sv
// Instruction/readback bundle for alu_regfile_pipe.
// Latency: none (wires only).
// Backpressure: none; the master owns instr_valid/instr/rd_addr, the slave owns results.
//
// Signals
//   instr_valid  instruction strobe (level or async edge, depending on the slave)
//   instr        {op[1:0], x, y, z}
//   rd_addr      readback register select
//   rd_data      architectural register contents at rd_addr
//   flag_c       carry / no-borrow of the last arithmetic op
//   flag_z       zero result of the last arithmetic op
//   wb_valid     one-cycle writeback pulse
//   wb_addr      register written when wb_valid is high
interface alu_regfile_pipe_if #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4
);
  localparam int RA_W    = $clog2(NREGS);
  localparam int INSTR_W = 2 + 3 * RA_W;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [RA_W-1:0]    rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic               flag_c;
  logic               flag_z;
  logic               wb_valid;
  logic [RA_W-1:0]    wb_addr;

  modport master (
    output instr_valid,
    output instr,
    output rd_addr,
    input  rd_data,
    input  flag_c,
    input  flag_z,
    input  wb_valid,
    input  wb_addr
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  rd_addr,
    output rd_data,
    output flag_c,
    output flag_z,
    output wb_valid,
    output wb_addr
  );
endinterface

// File: rtl/alu_regfile_pipe.sv
// Register-file mini ALU, two stages: execute-latch on accept, register writeback next edge.
// Latency: writeback (wb_valid, register, flags) one clock after the accepting edge.
// Backpressure: none; accepts every qualifying edge at full rate, never stalls.
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of alu_regfile_pipe_if (instr_valid, instr, rd_addr in;
//          rd_data, flag_c, flag_z, wb_valid, wb_addr out)
// Parameters
//   DATA_W       register width (>= 2*RA_W + 1)
//   NREGS        register count, power of two, >= 2
//   STROBE_EDGE  1: instr_valid is asynchronous, synchronised and rising-edge detected
//                0: instr_valid is a synchronous per-clock level
module alu_regfile_pipe #(
  parameter int DATA_W      = 8,
  parameter int NREGS       = 4,
  parameter int STROBE_EDGE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_regfile_pipe_if.slave bus
);

  localparam int RA_W    = $clog2(NREGS);
  localparam int IMM_W   = 2 * RA_W;
  localparam int INSTR_W = 2 + 3 * RA_W;

  typedef enum logic [1:0] {
    OP_LDI = 2'b00,
    OP_SHL = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  // ---------------------------------------------------------------------
  // Accept qualification
  // ---------------------------------------------------------------------
  logic accept;

  if (STROBE_EDGE != 0) begin : g_strobe
    // The arming FSM waits until the synchroniser has really sampled the
    // input (two edges after reset) and then for one low sample, so a
    // strobe held high through reset release never produces an accept.
    typedef enum logic [1:0] {
      SY_FILL0    = 2'd0,
      SY_FILL1    = 2'd1,
      SY_WAIT_LOW = 2'd2,
      SY_ARMED    = 2'd3
    } sync_e;

    sync_e sy_q;
    sync_e sy_d;
    logic  s1;
    logic  s2;
    logic  s3;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1   <= 1'b0;
        s2   <= 1'b0;
        s3   <= 1'b0;
        sy_q <= SY_FILL0;
      end else begin
        s1   <= bus.instr_valid;
        s2   <= s1;
        s3   <= s2;
        sy_q <= sy_d;
      end
    end

    always_comb begin
      sy_d = sy_q;
      case (sy_q)
        SY_FILL0:    sy_d = SY_FILL1;
        SY_FILL1:    sy_d = SY_WAIT_LOW;
        SY_WAIT_LOW: if (!s2) sy_d = SY_ARMED;
        SY_ARMED:    sy_d = SY_ARMED;
        default:     sy_d = SY_FILL0;
      endcase
    end

    // One accept per synchronised rising edge.
    assign accept = (sy_q == SY_ARMED) & s2 & ~s3;
  end else begin : g_level
    assign accept = bus.instr_valid;
  end

  // ---------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------
  op_e             in_op;
  logic [RA_W-1:0] in_x;
  logic [RA_W-1:0] in_y;
  logic [RA_W-1:0] in_z;
  logic [IMM_W-1:0] in_imm;

  assign in_op  = op_e'(bus.instr[INSTR_W-1 -: 2]);
  assign in_x   = bus.instr[3*RA_W-1 -: RA_W];
  assign in_y   = bus.instr[2*RA_W-1 -: RA_W];
  assign in_z   = bus.instr[RA_W-1:0];
  assign in_imm = bus.instr[3*RA_W-1:RA_W];    // {x, y}

  // ---------------------------------------------------------------------
  // Architectural state and pipeline registers
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] regs [NREGS];
  logic              flag_c_q;
  logic              flag_z_q;
  logic              wb_valid_q;
  logic [RA_W-1:0]   wb_addr_q;

  logic              e_vld;
  op_e               e_op;
  logic [RA_W-1:0]   e_z;
  logic [IMM_W-1:0]  e_imm;
  logic [DATA_W-1:0] e_a;
  logic [DATA_W-1:0] e_b;
  logic [DATA_W-1:0] e_zold;

  // Result of the instruction currently in W.
  logic [DATA_W-1:0] res;
  logic              res_c;
  logic              res_arith;
  logic [DATA_W:0]   arith_w;

  always_comb begin
    res       = '0;
    res_c     = 1'b0;
    res_arith = 1'b0;
    arith_w   = '0;
    case (e_op)
      OP_LDI: res = {{(DATA_W-IMM_W){1'b0}}, e_imm};
      OP_SHL: res = {e_zold[DATA_W-IMM_W-1:0], e_imm};
      OP_ADD: begin
        arith_w   = {1'b0, e_a} + {1'b0, e_b};
        res       = arith_w[DATA_W-1:0];
        res_c     = arith_w[DATA_W];
        res_arith = 1'b1;
      end
      OP_SUB: begin
        // The extra leading 1 survives exactly when A >= B (no borrow).
        arith_w   = {1'b1, e_a} - {1'b0, e_b};
        res       = arith_w[DATA_W-1:0];
        res_c     = arith_w[DATA_W];
        res_arith = 1'b1;
      end
      default: res = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Operand fetch with forwarding: the instruction in W has not yet
  // reached the register file on the edge that accepts its successor.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] op_zold;

  always_comb begin
    op_a    = regs[in_y];
    op_b    = regs[in_x];
    op_zold = regs[in_z];
    if (e_vld) begin
      if (e_z == in_y) op_a    = res;
      if (e_z == in_x) op_b    = res;
      if (e_z == in_z) op_zold = res;
    end
  end

  // Stage E: capture the accepted instruction and its operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld  <= 1'b0;
      e_op   <= OP_LDI;
      e_z    <= '0;
      e_imm  <= '0;
      e_a    <= '0;
      e_b    <= '0;
      e_zold <= '0;
    end else begin
      e_vld <= accept;
      if (accept) begin
        e_op   <= in_op;
        e_z    <= in_z;
        e_imm  <= in_imm;
        e_a    <= op_a;
        e_b    <= op_b;
        e_zold <= op_zold;
      end
    end
  end

  // Stage W: commit result, flags and the writeback pulse together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
    end else begin
      wb_valid_q <= e_vld;
      if (e_vld) begin
        regs[e_z] <= res;
        wb_addr_q <= e_z;
        if (res_arith) begin
          flag_c_q <= res_c;
          flag_z_q <= (res == '0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.rd_data  = regs[bus.rd_addr];
  assign bus.flag_c   = flag_c_q;
  assign bus.flag_z   = flag_z_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_addr  = wb_addr_q;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Bench for alu_regfile_pipe: level-valid instance checked every cycle against an
// instruction-level model; edge-strobe instance checked for pulse count and latency.
module tb_alu_regfile_pipe;

  localparam logic [1:0] LDI = 2'b00;
  localparam logic [1:0] SHL = 2'b01;
  localparam logic [1:0] ADD = 2'b10;
  localparam logic [1:0] SUB = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_regfile_pipe_if #(.DATA_W(8), .NREGS(4)) if0 ();
  alu_regfile_pipe_if #(.DATA_W(8), .NREGS(4)) if1 ();

  alu_regfile_pipe #(.DATA_W(8), .NREGS(4), .STROBE_EDGE(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  alu_regfile_pipe #(.DATA_W(8), .NREGS(4), .STROBE_EDGE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct {
    int         due;
    logic [1:0] z;
    logic [7:0] res;
    bit         upd;
    bit         c;
    bit         zf;
  } wb_t;

  logic [7:0] isa_r [4];   // state after every issued instruction, in order
  logic [7:0] vis_r [4];   // state as it must appear on rd_data
  bit         vis_c;
  bit         vis_z;
  wb_t        wb_q [$];
  int         cyc = 0;
  bit         chk_en = 1'b0;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      isa_r[i] = 8'h00;
      vis_r[i] = 8'h00;
    end
    vis_c = 1'b0;
    vis_z = 1'b0;
    wb_q.delete();
  endtask

  // Called at a negedge: the DUT accepts at the next posedge and writes back
  // one posedge later, so the pulse is due two sample points from now.
  task automatic issue(input logic [1:0] op, input logic [1:0] x, input logic [1:0] y,
                       input logic [1:0] z);
    wb_t e;
    int  a, b, old, imm, sum;
    a   = int'(isa_r[y]);
    b   = int'(isa_r[x]);
    old = int'(isa_r[z]);
    imm = int'(x) * 4 + int'(y);
    e.upd = 1'b0;
    e.c   = 1'b0;
    case (op)
      LDI: e.res = 8'(imm);
      SHL: e.res = 8'((old * 16 + imm) % 256);
      ADD: begin
        sum   = a + b;
        e.res = 8'(sum % 256);
        e.c   = (sum > 255);
        e.upd = 1'b1;
      end
      default: begin
        e.res = 8'((a - b + 256) % 256);
        e.c   = (a >= b);
        e.upd = 1'b1;
      end
    endcase
    e.zf     = (e.res == 8'h00);
    e.z      = z;
    e.due    = cyc + 2;
    isa_r[z] = e.res;
    wb_q.push_back(e);
    if0.instr       = {op, x, y, z};
    if0.instr_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    if0.instr_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    if0.instr_valid = 1'b0;
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lit(input string name, input logic [1:0] addr, input logic [7:0] exp);
    if0.rd_addr = addr;
    #1;
    check(name, if0.rd_data, exp);
  endtask

  // ---------------- per-cycle compare ----------------
  always begin
    wb_t e;
    bit  exp_wb;
    @(posedge clk);
    #2;
    cyc++;
    if (chk_en) begin
      while (wb_q.size() > 0 && wb_q[0].due < cyc) begin
        e = wb_q.pop_front();
        check("wb_missed_slot", 32'(e.due), 32'(cyc));
      end
      exp_wb = (wb_q.size() > 0) && (wb_q[0].due == cyc);
      check("wb_valid", if0.wb_valid, exp_wb);
      if (exp_wb) begin
        e = wb_q.pop_front();
        check("wb_addr", if0.wb_addr, e.z);
        vis_r[e.z] = e.res;
        if (e.upd) begin
          vis_c = e.c;
          vis_z = e.zf;
        end
      end
      check("rd_data", if0.rd_data, vis_r[if0.rd_addr]);
      check("flag_c", if0.flag_c, vis_c);
      check("flag_z", if0.flag_z, vis_z);
    end
  end

  // ---------------- edge-strobe pulse counter ----------------
  task automatic count_pulses(input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (if1.wb_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int p, lat;
    if0.instr_valid = 1'b0;
    if0.instr       = '0;
    if0.rd_addr     = '0;
    if1.instr_valid = 1'b0;
    if1.instr       = {LDI, 2'd0, 2'd3, 2'd2};   // LDI r2 <- 3
    if1.rd_addr     = 2'd2;
    model_clear();
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;

    // Reset state
    lit("rst_r0", 2'd0, 8'h00);
    lit("rst_r3", 2'd3, 8'h00);
    check("rst_wb_valid", if0.wb_valid, 1'b0);
    check("rst_flags", {if0.flag_c, if0.flag_z}, 2'b00);

    // T2: LDI r1 <- A, SHL r1 <- 5 (back to back, Zold forwarded)
    issue(LDI, 2'd2, 2'd2, 2'd1);
    issue(SHL, 2'd1, 2'd1, 2'd1);
    idle(3);
    lit("t2_r1", 2'd1, 8'hA5);

    // T3: r0=F0, r1=20, ADD -> r2=10, carry
    issue(LDI, 2'd3, 2'd3, 2'd0);
    issue(SHL, 2'd0, 2'd0, 2'd0);
    issue(LDI, 2'd0, 2'd2, 2'd1);
    issue(SHL, 2'd0, 2'd0, 2'd1);
    issue(ADD, 2'd0, 2'd1, 2'd2);
    idle(3);
    lit("t3_r2", 2'd2, 8'h10);
    check("t3_flags", {if0.flag_c, if0.flag_z}, 2'b10);

    // T4: r1=05, r0=05 -> SUB r3 = 00; then r0=06 -> FF
    issue(LDI, 2'd0, 2'd0, 2'd1);
    issue(SHL, 2'd1, 2'd1, 2'd1);
    issue(LDI, 2'd0, 2'd0, 2'd0);
    issue(SHL, 2'd1, 2'd1, 2'd0);
    issue(SUB, 2'd0, 2'd1, 2'd3);
    idle(3);
    lit("t4_r3_eq", 2'd3, 8'h00);
    check("t4_flags_eq", {if0.flag_c, if0.flag_z}, 2'b11);
    issue(LDI, 2'd0, 2'd0, 2'd0);
    issue(SHL, 2'd1, 2'd2, 2'd0);
    issue(SUB, 2'd0, 2'd1, 2'd3);
    idle(2);
    // LDI after SUB must leave the flags alone
    issue(LDI, 2'd1, 2'd1, 2'd2);
    idle(3);
    lit("t4_r3_borrow", 2'd3, 8'hFF);
    check("t4_flags_borrow", {if0.flag_c, if0.flag_z}, 2'b00);

    // T5: LDI r3 <- 7 then ADD r3+r3 -> r0 next clock (forwarded)
    issue(LDI, 2'd1, 2'd3, 2'd3);
    issue(ADD, 2'd3, 2'd3, 2'd0);
    idle(3);
    lit("t5_r0", 2'd0, 8'h0E);

    // Same register as x, y and z: r1 (05) doubles
    issue(ADD, 2'd1, 2'd1, 2'd1);
    idle(3);
    lit("dbl_r1", 2'd1, 8'h0A);

    // T1: reset with a write in flight (accepted, not yet written back)
    issue(LDI, 2'd3, 2'd3, 2'd2);
    do_reset();
    lit("t1_r2", 2'd2, 8'h00);
    lit("t1_r1", 2'd1, 8'h00);
    check("t1_flags", {if0.flag_c, if0.flag_z}, 2'b00);
    idle(3);
    lit("t1_r2_late", 2'd2, 8'h00);

    // T6: edge-strobe instance
    idle(5);
    if1.instr_valid = 1'b1;
    count_pulses(50, p, lat);
    check("t6_pulses_held", p, 1);
    check("t6_latency_in_2_to_4", (lat >= 2 && lat <= 4), 1'b1);
    check("t6_r2", if1.rd_data, 8'h03);
    if1.instr_valid = 1'b0;
    count_pulses(6, p, lat);
    check("t6_pulses_low", p, 0);
    if1.instr_valid = 1'b1;
    count_pulses(20, p, lat);
    check("t6_pulses_rearm", p, 1);

    // Strobe held high across reset release: no accept until it drops
    do_reset();
    count_pulses(30, p, lat);
    check("t6_held_over_reset", p, 0);
    check("t6_r2_after_reset", if1.rd_data, 8'h00);
    if1.instr_valid = 1'b0;
    count_pulses(6, p, lat);
    if1.instr_valid = 1'b1;
    count_pulses(20, p, lat);
    check("t6_after_low_again", p, 1);
    if1.instr_valid = 1'b0;

    idle(4);
    chk_en = 1'b0;
    check("queue_drained", wb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
